// File: rtl/demux_pkg.sv
// Shared constants and mode encoding for the lane demultiplexer.
package demux_pkg;

  localparam int unsigned NUM_LANES = 8;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic {
    MODE_RR   = 1'b0,
    MODE_ADDR = 1'b1
  } mode_e;

endpackage : demux_pkg

// File: rtl/sel_decoder_3to8.sv
// 3-to-8 one-hot decoder with enable; output is all zero when disabled.
module sel_decoder_3to8
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0]     sel,
  input  logic                 en,
  output logic [NUM_LANES-1:0] onehot
);

  // Single hot bit at the selected position when enabled
  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule : sel_decoder_3to8

// File: rtl/demux_rr_scheduler.sv
// Distributes an input word stream over 8 single-entry lane buffers,
// either round-robin over free lanes or to an addressed lane.
module demux_rr_scheduler
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_LANES = demux_pkg::NUM_LANES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mode,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [SEL_W-1:0]              in_dest,
  output logic [NUM_LANES-1:0]          out_valid,
  input  logic [NUM_LANES-1:0]          out_ready,
  output logic [NUM_LANES*DATA_W-1:0]   out_data,
  output logic [SEL_W-1:0]              last_lane,
  output logic [CNT_W-1:0]              accept_cnt
);

  mode_e                mode_sel;
  logic [NUM_LANES-1:0] valid_q, valid_d;
  logic [DATA_W-1:0]    data_q [NUM_LANES];
  logic [DATA_W-1:0]    data_d [NUM_LANES];
  logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]     last_lane_q, last_lane_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 rr_found;
  logic [SEL_W-1:0]     rr_lane;
  logic [SEL_W-1:0]     target;
  logic                 target_free;
  logic                 xfer;
  logic [NUM_LANES-1:0] wr_onehot;

  assign mode_sel = mode_e'(mode);

  // First free lane searching upward from rr_ptr, wrapping 7 -> 0
  always_comb begin
    logic [SEL_W-1:0] cand;
    rr_found = 1'b0;
    rr_lane  = rr_ptr_q;
    cand     = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      cand = rr_ptr_q + SEL_W'(i);
      if (!rr_found && !valid_q[cand]) begin
        rr_found = 1'b1;
        rr_lane  = cand;
      end
    end
  end

  // Target lane and acceptance; in_ready looks only at registered lane state
  always_comb begin
    target      = rr_lane;
    target_free = rr_found;
    if (mode_sel == MODE_ADDR) begin
      target      = in_dest;
      target_free = !valid_q[in_dest];
    end
    in_ready = rst_n && !flush && target_free;
    xfer     = in_valid && in_ready;
  end

  sel_decoder_3to8 u_sel_dec (
    .sel    (target),
    .en     (xfer),
    .onehot (wr_onehot)
  );

  // Next-state for lane flags, pointer, last lane and saturating counter
  always_comb begin
    // a drained lane is never the write target in the same cycle, so
    // clear-then-set cannot collide
    valid_d = valid_q & ~out_ready;
    if (flush) valid_d = '0;
    else       valid_d = valid_d | wr_onehot;

    rr_ptr_d = rr_ptr_q;
    if (flush) rr_ptr_d = '0;
    else if (xfer && mode_sel == MODE_RR) rr_ptr_d = target + SEL_W'(1);

    last_lane_d = xfer ? target : last_lane_q;

    cnt_d = cnt_q;
    if (xfer && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  // Lane data capture on write
  always_comb begin
    data_d = data_q;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (wr_onehot[i]) data_d[i] = in_data;
    end
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      rr_ptr_q    <= '0;
      last_lane_q <= '0;
      cnt_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      rr_ptr_q    <= rr_ptr_d;
      last_lane_q <= last_lane_d;
      cnt_q       <= cnt_d;
    end
  end

  // Lane data registers, intentionally not reset
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  // Flatten lane data onto the output bus
  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      out_data[i*DATA_W +: DATA_W] = data_q[i];
    end
  end

  assign out_valid  = valid_q;
  assign last_lane  = last_lane_q;
  assign accept_cnt = cnt_q;

endmodule : demux_rr_scheduler

// File: tb/tb_demux_rr_scheduler.sv
// Directed bench for demux_rr_scheduler with a reference model checked every cycle.
module tb_demux_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [2:0]  in_dest;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [63:0] out_data;
  logic [2:0]  last_lane;
  logic [15:0] accept_cnt;

  int total = 0;
  int bad   = 0;

  demux_rr_scheduler #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .last_lane  (last_lane),
    .accept_cnt (accept_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit       mvalid [8];
  bit [7:0] mdata  [8];
  int       mptr;
  int       mlast;
  int       mcnt;

  function automatic bit m_ready();
    bit any_free = 0;
    if (!rst_n || flush) return 0;
    if (mode == 1'b1) return !mvalid[in_dest];
    for (int k = 0; k < 8; k++) if (!mvalid[k]) any_free = 1;
    return any_free;
  endfunction

  function automatic int m_target();
    if (mode == 1'b1) return int'(in_dest);
    for (int k = 0; k < 8; k++) begin
      if (!mvalid[(mptr + k) % 8]) return (mptr + k) % 8;
    end
    return 0;
  endfunction

  function automatic logic [7:0] m_valid_vec();
    logic [7:0] v = '0;
    for (int k = 0; k < 8; k++) v[k] = mvalid[k];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) mvalid[k] = 0;
      mptr  = 0;
      mlast = 0;
      mcnt  = 0;
    end else begin
      bit rdy;
      int tgt;
      rdy = m_ready();
      tgt = m_target();
      for (int k = 0; k < 8; k++) if (mvalid[k] && out_ready[k]) mvalid[k] = 0;
      if (flush) begin
        for (int k = 0; k < 8; k++) mvalid[k] = 0;
        mptr = 0;
      end else if (in_valid && rdy) begin
        mvalid[tgt] = 1;
        mdata[tgt]  = in_data;
        mlast       = tgt;
        if (mcnt < 65535) mcnt++;
        if (mode == 1'b0) mptr = (tgt + 1) % 8;
      end
    end
  end

  // Compare DUT against model once per cycle, away from the rising edge
  always @(negedge clk) begin
    #2;
    chk("out_valid", 64'(out_valid), 64'(m_valid_vec()));
    chk("in_ready", 64'(in_ready), 64'(m_ready()));
    chk("last_lane", 64'(last_lane), 64'(mlast));
    chk("accept_cnt", 64'(accept_cnt), 64'(mcnt));
    for (int k = 0; k < 8; k++) begin
      if (mvalid[k]) chk("lane_data", 64'(out_data[k*8 +: 8]), 64'(mdata[k]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; mode = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; in_dest = '0; out_ready = '0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_cnt", 64'(accept_cnt), 64'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // fill all eight lanes round-robin; ninth word must stall
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(k);
      if (k == 8) begin
        #1;
        chk("fill_in_ready_9th", 64'(in_ready), 64'h0);
        chk("fill_out_valid", 64'(out_valid), 64'hFF);
        chk("fill_cnt", 64'(accept_cnt), 64'd8);
        chk("fill_last", 64'(last_lane), 64'd7);
      end
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 8'hFF;
    @(negedge clk); out_ready = 8'h00;

    // lanes 2,3 full with rr_ptr = 2
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); mode = 1'b0; in_valid = 1'b1; in_data = 8'hA0 + 8'(k);
    end
    for (int k = 2; k < 4; k++) begin
      @(negedge clk); mode = 1'b1; in_dest = 3'(k); in_data = 8'hB0 + 8'(k);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 8'h03;
    @(negedge clk); out_ready = 8'h00; mode = 1'b0; in_valid = 1'b1; in_data = 8'hC4;
    @(negedge clk); in_data = 8'hC5; #1;
    chk("rr_skip_last", 64'(last_lane), 64'd4);
    chk("rr_skip_data", 64'(out_data[4*8 +: 8]), 64'hC4);
    @(negedge clk); in_valid = 1'b0; #1;
    chk("rr_ptr_after", 64'(last_lane), 64'd5);
    chk("rr_valid", 64'(out_valid), 64'h3C);

    // addressed write into a full lane that drains this edge
    @(negedge clk);
    mode = 1'b1; in_dest = 3'd5; in_valid = 1'b1; in_data = 8'h55; out_ready = 8'h20;
    #1;
    chk("drain_no_refill", 64'(in_ready), 64'h0);
    @(negedge clk); #1;
    chk("drain_cleared", 64'(out_valid[5]), 64'h0);
    chk("drain_ready_next", 64'(in_ready), 64'h1);
    out_ready = 8'h00;
    @(negedge clk); in_valid = 1'b0; #1;
    chk("drain_refill_data", 64'(out_data[5*8 +: 8]), 64'h55);
    chk("drain_refill_cnt", 64'(accept_cnt), 64'd15);

    // build 8'hA5 then flush with a word offered
    @(negedge clk); out_ready = 8'hFF;
    @(negedge clk); out_ready = 8'h00;
    foreach (mvalid[k]) begin
      if (k == 0 || k == 2 || k == 5 || k == 7) begin
        @(negedge clk); mode = 1'b1; in_valid = 1'b1; in_dest = 3'(k); in_data = 8'hD0 + 8'(k);
      end
    end
    @(negedge clk); #1;
    chk("pre_flush_valid", 64'(out_valid), 64'hA5);
    mode = 1'b0; flush = 1'b1; in_data = 8'hEE;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'h0);
    @(negedge clk); flush = 1'b0; #1;
    chk("flush_valid", 64'(out_valid), 64'h00);
    chk("flush_cnt", 64'(accept_cnt), 64'd19);
    chk("flush_last", 64'(last_lane), 64'd7);
    in_data = 8'h60;
    @(negedge clk); in_valid = 1'b0; #1;
    chk("flush_ptr_zero", 64'(last_lane), 64'd0);

    // build 8'h0F then reset between edges
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 8'h60 + 8'(k);
    end
    @(negedge clk); in_valid = 1'b0; #1;
    chk("pre_rst_valid", 64'(out_valid), 64'h0F);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'h00);
    chk("async_rst_cnt", 64'(accept_cnt), 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'h0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    @(negedge clk); #1;
    chk("first_after_rst_cnt", 64'(accept_cnt), 64'd1);

    // sustained stream up to and beyond counter saturation
    out_ready = 8'hFF;
    for (int k = 0; k < 65533; k++) begin
      in_data = 8'(k * 7 + 3);
      @(negedge clk);
    end
    #1;
    chk("sat_fffe", 64'(accept_cnt), 64'hFFFE);
    for (int k = 0; k < 3; k++) begin
      in_data = 8'(k + 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("sat_ffff", 64'(accept_cnt), 64'hFFFF);
    chk("sat_last", 64'(last_lane), 64'd0);

    repeat (3) @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_demux_rr_scheduler
